// File: rtl/dta_ingr_snd_monitor_pkg.sv
// Shared definitions for the ingress-send protocol monitor slice.
//  - Default widths for the error collector (ERR_W, CNT_W, TS_W).
//  - Bit positions of the monitor's protocol_error vector.
//  - Collector FSM state encoding.
package dta_ingr_snd_monitor_pkg;

    localparam int ERR_W_DEF = 16;
    localparam int CNT_W_DEF = 32;
    localparam int TS_W_DEF  = 48;

    // Fault vector layout: bits 0..13 are monitor checks, 10/11/14/15 are reserved.
    localparam int FE_RESP_CHANNEL_EQ_REQ      = 0;
    localparam int FE_RESP_BURST_LENGTH_EQ_REQ = 13;
    localparam logic [15:0] FE_RESERVED_MASK   = 16'hCC00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no sticky error held
        S_ERR  = 2'd1,   // at least one sticky error held
        S_CLR  = 2'd2    // one-cycle application of an accepted clear
    } state_t;

endpackage

// File: rtl/dta_sat_counter.sv
// Saturating up-counter.
//  clk/rst : clock, asynchronous active-high reset
//  inc     : add one this cycle (ignored once all-ones)
//  clr     : reload; counter becomes 1 if inc is also high, else 0
//  cnt     : current count
module dta_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dta_ingr_snd_protocol_error_collector.sv
// Protocol error collector: accumulates sticky faults from the ingress-send
// monitor, captures the first event, counts event cycles and raises a level
// interrupt. Host clears through a valid/ready W1C channel.
//  ap_clk, ap_rst                      : clock, asynchronous active-high reset
//  protocol_error/_ap_vld              : fault vector and its qualifier
//  error_mask                          : 1 = ignore that fault bit
//  clr_valid/clr_ready/clr_data/clr_cnt: W1C request (clr_cnt zeroes the counter)
//  sticky_error, error_irq             : accumulated faults, level interrupt
//  first_error, first_error_vld        : first captured event vector
//  error_event_count                   : saturating event-cycle count
//  first_error_ts                      : timestamp of first event
// Optional feature: define PROTOCOL_ERROR_TIMESTAMP_EN to add the free-running
// timestamp counter and the first_error_ts port.
module dta_ingr_snd_protocol_error_collector
    import dta_ingr_snd_monitor_pkg::*;
#(
    parameter int ERR_W = ERR_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [ERR_W-1:0] protocol_error,
    input  logic             protocol_error_ap_vld,
    input  logic [ERR_W-1:0] error_mask,
    input  logic             clr_valid,
    output logic             clr_ready,
    input  logic [ERR_W-1:0] clr_data,
    input  logic             clr_cnt,
    output logic [ERR_W-1:0] sticky_error,
    output logic [ERR_W-1:0] first_error,
    output logic             first_error_vld,
    output logic [CNT_W-1:0] error_event_count,
    output logic             error_irq
`ifdef PROTOCOL_ERROR_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  first_error_ts
`endif
);

    state_t           state, state_next;
    logic [ERR_W-1:0] ev_vec, ev_set, sticky_next, kept, clr_q;
    logic             ev_hit, clr_take, cnt_clr, cap, drop, clr_cnt_q;

    always_comb begin
        ev_vec      = protocol_error & ~error_mask;
        ev_hit      = protocol_error_ap_vld && (ev_vec != '0);
        ev_set      = ev_hit ? ev_vec : '0;
        kept        = sticky_error;
        clr_take    = 1'b0;
        cnt_clr     = 1'b0;
        cap         = ev_hit && !first_error_vld;
        drop        = 1'b0;
        sticky_next = sticky_error | ev_set;
        state_next  = state;
        case (state)
            S_CLR: begin
                kept        = sticky_error & ~clr_q;
                sticky_next = kept | ev_set;
                cnt_clr     = clr_cnt_q;
                // Clear empties the surviving bits: the first-error record is
                // released, unless this very cycle brings a new event to capture.
                if (kept == '0) begin
                    cap  = ev_hit;
                    drop = !ev_hit;
                end
                state_next = (sticky_next != '0) ? S_ERR : S_IDLE;
            end
            default: begin
                clr_take   = clr_valid && clr_ready;
                state_next = clr_take ? S_CLR :
                             (sticky_next != '0) ? S_ERR : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state           <= S_IDLE;
            sticky_error    <= '0;
            error_irq       <= 1'b0;
            first_error     <= '0;
            first_error_vld <= 1'b0;
            clr_ready       <= 1'b0;
            clr_q           <= '0;
            clr_cnt_q       <= 1'b0;
        end else begin
            state        <= state_next;
            sticky_error <= sticky_next;
            error_irq    <= (sticky_next != '0);
            // Registered ready: low through reset and during the S_CLR cycle.
            clr_ready    <= (state_next != S_CLR);
            if (clr_take) begin
                clr_q     <= clr_data;
                clr_cnt_q <= clr_cnt;
            end
            if (cap) begin
                first_error     <= ev_vec;
                first_error_vld <= 1'b1;
            end else if (drop) begin
                first_error     <= '0;
                first_error_vld <= 1'b0;
            end
        end
    end

`ifdef PROTOCOL_ERROR_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ts             <= '0;
            first_error_ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (cap) begin
                first_error_ts <= ts;
            end else if (drop) begin
                first_error_ts <= '0;
            end
        end
    end
`endif

    dta_sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk (ap_clk),
        .rst (ap_rst),
        .inc (ev_hit),
        .clr (cnt_clr),
        .cnt (error_event_count)
    );

endmodule
